// File: rtl/sm3_msg_arb_if.sv
// sm3_msg_arb_if -- bundle of the request and pad-core buses around sm3_msg_arb.
//
//   Requester side : req_vld, req_d, req_vld_byte, req_lst (to arbiter),
//                    req_rdy (from arbiter). Channel i occupies slice
//                    [i*DW +: DW] of req_d and [i*DW/8 +: DW/8] of req_vld_byte.
//   Pad-core side  : msg_inpt_d, msg_inpt_vld_byte, msg_inpt_vld, msg_inpt_lst
//                    (from arbiter), msg_inpt_rdy, sm3_done (to arbiter).
//   Status         : cur_ch, busy, done_unexp (from arbiter).
//
// modport slave  : the arbiter's view.
// modport master : the surrounding system's view (requesters + pad core).
interface sm3_msg_arb_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DW     = 32
);
  localparam int unsigned CW = $clog2(NUM_CH);

  logic [NUM_CH-1:0]        req_vld;
  logic [NUM_CH*DW-1:0]     req_d;
  logic [NUM_CH*DW/8-1:0]   req_vld_byte;
  logic [NUM_CH-1:0]        req_lst;
  logic [NUM_CH-1:0]        req_rdy;

  logic [DW-1:0]            msg_inpt_d;
  logic [DW/8-1:0]          msg_inpt_vld_byte;
  logic                     msg_inpt_vld;
  logic                     msg_inpt_lst;
  logic                     msg_inpt_rdy;
  logic                     sm3_done;

  logic [CW-1:0]            cur_ch;
  logic                     busy;
  logic                     done_unexp;

  modport slave (
    input  req_vld, req_d, req_vld_byte, req_lst, msg_inpt_rdy, sm3_done,
    output req_rdy, msg_inpt_d, msg_inpt_vld_byte, msg_inpt_vld, msg_inpt_lst,
           cur_ch, busy, done_unexp
  );

  modport master (
    output req_vld, req_d, req_vld_byte, req_lst, msg_inpt_rdy, sm3_done,
    input  req_rdy, msg_inpt_d, msg_inpt_vld_byte, msg_inpt_vld, msg_inpt_lst,
           cur_ch, busy, done_unexp
  );
endinterface

// File: rtl/sm3_msg_arb.sv
// sm3_msg_arb -- lets NUM_CH requesters share one SM3 padding/expansion/
// compression datapath, one complete message at a time.
//
// Ports:
//   clk  : clock
//   rst  : asynchronous, active-high reset
//   bus  : sm3_msg_arb_if.slave (requests in, granted beats out to the pad
//          core, sm3_done back, cur_ch/busy/done_unexp status)
//
// Flow: IDLE picks a winner and registers it into cur_ch, XFER passes that
// channel's beats through combinationally until the lst beat transfers, WAIT
// holds everything off until sm3_done, then back to IDLE.
//
// Build options:
//   SM3_ARB_RR_EN   defined: round-robin starting at the pointer, pointer
//                   moves to cur_ch+1 on WAIT->IDLE.
//                   undefined: fixed priority, lowest index wins.
//   SM3_INPT_DW_64  defined: 64-bit beats, otherwise 32-bit beats.
//                   The instantiated interface must use the same DW/NUM_CH.
module sm3_msg_arb #(
  parameter int unsigned NUM_CH = 4
) (
  input  logic        clk,
  input  logic        rst,
  sm3_msg_arb_if.slave bus
);

`ifdef SM3_INPT_DW_64
  localparam int unsigned DW = 64;
`else
  localparam int unsigned DW = 32;
`endif
  localparam int unsigned BW = DW / 8;
  localparam int unsigned CW = $clog2(NUM_CH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cur_ch_q, cur_ch_d;
  logic              done_unexp_q, done_unexp_d;

  logic [CW-1:0]     win_ch;
  logic              win_vld;

  logic [DW-1:0]     sel_d;
  logic [BW-1:0]     sel_vb;
  logic              sel_vld;
  logic              sel_lst;

  logic              in_xfer;
  logic              out_vld;
  logic              beat_xfer;
  logic [NUM_CH-1:0] req_rdy;
  logic [CW-1:0]     next_ch;

  assign next_ch = (cur_ch_q == CW'(NUM_CH - 1)) ? '0 : cur_ch_q + 1'b1;

`ifdef SM3_ARB_RR_EN
  logic [CW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW:0]   dist;
  logic [CW:0]   best_dist;

  // Winner is the requester with the smallest upward distance from the
  // pointer (with wrap); scanning by distance keeps every bit select constant.
  always_comb begin
    win_ch    = '0;
    win_vld   = 1'b0;
    dist      = '0;
    best_dist = '0;
    for (int unsigned j = 0; j < NUM_CH; j++) begin
      if ((CW+1)'(j) >= {1'b0, rr_ptr_q}) begin
        dist = (CW+1)'(j) - {1'b0, rr_ptr_q};
      end else begin
        dist = (CW+1)'(j) + (CW+1)'(NUM_CH) - {1'b0, rr_ptr_q};
      end
      if (bus.req_vld[j] && (!win_vld || (dist < best_dist))) begin
        win_vld   = 1'b1;
        win_ch    = CW'(j);
        best_dist = dist;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if ((state_q == ST_WAIT) && bus.sm3_done) begin
      rr_ptr_d = next_ch;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  always_comb begin
    win_ch  = '0;
    win_vld = 1'b0;
    for (int unsigned j = 0; j < NUM_CH; j++) begin
      if (bus.req_vld[j] && !win_vld) begin
        win_vld = 1'b1;
        win_ch  = CW'(j);
      end
    end
  end

  // The pointer only matters for round-robin; next_ch is otherwise unused.
  logic unused_next_ch;
  assign unused_next_ch = ^next_ch;
`endif

  // Granted channel's beat, selected by a constant-index scan.
  always_comb begin
    sel_d   = '0;
    sel_vb  = '0;
    sel_vld = 1'b0;
    sel_lst = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (cur_ch_q == CW'(i)) begin
        sel_d   = bus.req_d[i*DW +: DW];
        sel_vb  = bus.req_vld_byte[i*BW +: BW];
        sel_vld = bus.req_vld[i];
        sel_lst = bus.req_lst[i];
      end
    end
  end

  assign in_xfer   = (state_q == ST_XFER);
  assign out_vld   = in_xfer & sel_vld;
  assign beat_xfer = out_vld & bus.msg_inpt_rdy;

  always_comb begin
    req_rdy = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      req_rdy[i] = in_xfer && (cur_ch_q == CW'(i)) && bus.msg_inpt_rdy;
    end
  end

  always_comb begin
    state_d  = state_q;
    cur_ch_d = cur_ch_q;
    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          state_d  = ST_XFER;
          cur_ch_d = win_ch;
        end
      end
      ST_XFER: begin
        if (beat_xfer && sel_lst) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.sm3_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign done_unexp_d = done_unexp_q | (bus.sm3_done & (state_q != ST_WAIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cur_ch_q     <= '0;
      done_unexp_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_ch_q     <= cur_ch_d;
      done_unexp_q <= done_unexp_d;
    end
  end

  // Data, byte mask and lst are forced to zero whenever no beat is offered.
  assign bus.req_rdy           = req_rdy;
  assign bus.msg_inpt_vld      = out_vld;
  assign bus.msg_inpt_d        = out_vld ? sel_d  : '0;
  assign bus.msg_inpt_vld_byte = out_vld ? sel_vb : '0;
  assign bus.msg_inpt_lst      = out_vld & sel_lst;
  assign bus.cur_ch            = cur_ch_q;
  assign bus.busy              = (state_q == ST_XFER) || (state_q == ST_WAIT);
  assign bus.done_unexp        = done_unexp_q;

endmodule

// File: doc/sm3_msg_arb.md
# sm3_msg_arb

Multi-channel message arbiter in front of the SM3 padding core (sm3_pad_core → sm3_expnd_core → compress). It lets NUM_CH independent requesters share one SM3 datapath. It grants a complete message (first beat through `lst` beat) to one channel, muxes that channel's beats onto the `msg_inpt_*` bus, and holds off the next grant until the datapath reports hash completion. It also exports the owning channel ID so downstream logic can route the digest.

## Interface
- NUM_CH, 4: number of requesters, 2..8.
- DW, 32 or 64: input bus width, from `SM3_INPT_DW_32` / `SM3_INPT_DW_64` in sm3_cfg.v; not a free parameter.
- CW, $clog2(NUM_CH): channel ID width, derived.

- clk  in  1  clock.
- rst  in  1  reset; one clock, asynchronous and active-high.
- req_vld  in  NUM_CH  per-channel beat valid.
- req_d  in  NUM_CH*DW  per-channel data; channel i is at [i*DW +: DW]; big-endian bytes, as on msg_inpt_d.
- req_vld_byte  in  NUM_CH*DW/8  per-channel byte valid, MSB-first contiguous mask; meaningful only on the lst beat.
- req_lst  in  NUM_CH  per-channel last beat of the message.
- req_rdy  out  NUM_CH  per-channel beat accepted when req_vld & req_rdy.
- msg_inpt_d  out  DW  to pad core.
- msg_inpt_vld_byte  out  DW/8  to pad core.
- msg_inpt_vld  out  1  to pad core.
- msg_inpt_lst  out  1  to pad core.
- msg_inpt_rdy  in  1  pad core can take a beat this cycle.
- sm3_done  in  1  single-cycle pulse when the digest for the current message is valid.
- cur_ch  out  CW  owning channel; stable from grant until return to IDLE.
- busy  out  1  high in XFER and WAIT.
- done_unexp  out  1  sticky: sm3_done arrived outside WAIT; cleared only by rst.

## Operation
- States:
  - IDLE: no grant; all req_rdy = 0, msg_inpt_vld = 0.
    - If any req_vld is set, pick a winner (see Configuration), register it into cur_ch, and go to XFER.
  - XFER: pass-through for cur_ch only.
    - msg_inpt_d, vld_byte, vld and lst are driven from channel cur_ch. req_rdy[cur_ch] = msg_inpt_rdy. Other channels' req_rdy = 0.
    - A beat transfers on msg_inpt_vld & msg_inpt_rdy. A transfer with lst set goes to WAIT.
  - WAIT: msg_inpt_vld = 0, all req_rdy = 0. On sm3_done go to IDLE and advance the RR pointer to cur_ch+1 mod NUM_CH.
- Non-granted channels that assert req_vld keep their beat and wait; no data is lost.
- A single-beat message (vld & lst on the first XFER beat) goes XFER → WAIT after one transfer.
- sm3_done in IDLE or XFER is ignored for state and sets done_unexp.
- When msg_inpt_vld = 0, msg_inpt_d / vld_byte / lst are driven to 0.
- rst mid-message forces IDLE, cur_ch = 0, RR pointer = 0, and clears done_unexp. Recovering the pad core is the system reset's job.

## Timing
- Reset values: req_rdy = 0, msg_inpt_vld/lst = 0, msg_inpt_d = 0, msg_inpt_vld_byte = 0, cur_ch = 0, busy = 0, done_unexp = 0.
- Grant latency: req_vld seen high in IDLE at edge N → state = XFER and req_rdy valid in cycle N+1. One bubble per message.
- XFER datapath is combinational, so req → msg_inpt adds zero cycles. req_rdy follows msg_inpt_rdy in the same cycle (combinational).
- Throughput in XFER: one beat per cycle while req_vld & msg_inpt_rdy.
- lst transfer at edge M → WAIT from M+1. sm3_done at edge K → IDLE at K+1. The earliest next grant is XFER at K+2.
- A requester may drop req_vld between beats (bubbles allowed); the grant is held.
- State, cur_ch, RR pointer and done_unexp are flops. All other outputs are decoded from state and inputs.

## Configuration
- `SM3_ARB_RR_EN` defined: round-robin. The winner is the first set req_vld at or after the RR pointer, scanning upward with wrap. The pointer advances only on WAIT → IDLE.
- Not defined: fixed priority, lowest index wins. The RR pointer flop is not built.

## Test plan
- Single channel, 32-bit, ch2 sends 3 beats {01020304 ×2, 01020000 with vld_byte 1100, lst} → cur_ch = 2; pad core sees exactly those 3 beats. sm3_done 5 cycles later → IDLE; busy low the next cycle.
- Contention with RR enabled: ch0..ch3 all request at once, each sending one message → grant order 0,1,2,3. With the macro undefined and ch0 re-requesting after every done → ch0 granted every time.
- Backpressure: msg_inpt_rdy toggles 1,0,0,1 during a 4-beat ch1 message → req_rdy[1] mirrors msg_inpt_rdy each cycle, no beat duplicated or dropped, and req_rdy[0,2,3] stay 0.
- Early done: sm3_done pulses in XFER → state unchanged and done_unexp = 1; a later sm3_done in WAIT → IDLE, with done_unexp still 1.
- Reset mid-XFER: rst asserted after beat 2 of 5 → all outputs at reset values immediately, without waiting for a clock edge. After release, a new request is granted with one-bubble latency.
- Single-beat message with vld_byte 1000 → XFER lasts 1 cycle, then WAIT, with msg_inpt_lst = 1 on that beat.
